// File: rtl/instr_mem_loadable_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_loadable_pkg
//  Description : Shared types and constants for the loadable instruction memory.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_mem_loadable_pkg;

    localparam int c_instr_width = 16;
    localparam logic [c_instr_width-1:0] c_nop_opcode = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/instr_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_array
//  Description : Simple dual-port RAM, one synchronous write and one
//                synchronous read port. Contents are never reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_array #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 64,
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [IDX_W-1:0]      rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // rd_data holds its value when rd_en is low so the fetch output can stall.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= r_mem[rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_mem_loadable.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_loadable
//  Description : Run-time loadable instruction memory with a word-stream load
//                port and a 1-cycle-latency pipelined fetch port.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_loadable
    import instr_mem_loadable_pkg::*;
#(
    parameter int DATA_WIDTH = c_instr_width,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 64,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD = DATA_WIDTH'(c_nop_opcode)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic                  load_done,
    output logic [ADDR_WIDTH-1:0] load_count,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic                  fetch_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  addr_fault
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so counters and compares can represent DEPTH itself.
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] c_depth     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_count_max = CNT_W'((2 ** ADDR_WIDTH) - 1);

    state_t                r_state;
    logic [CNT_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_load_count;
    logic                  r_load_ready;
    logic                  r_load_done;
    logic                  r_fetch_ready;
    logic                  r_out_valid;
    logic                  r_addr_fault;
    logic                  r_use_nop;

    logic                  w_load_accept;
    logic                  w_last_word;
    logic                  w_fetch_accept;
    logic [CNT_W-1:0]      w_addr_ext;
    logic                  w_addr_oob;
    logic                  w_addr_loaded;
    logic                  w_rd_en;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_load_accept  = (r_state == LOAD) && load_valid && r_load_ready && !load_start;
    assign w_last_word    = load_last || (r_wr_ptr == (c_depth - c_one));
    assign w_fetch_accept = fetch_req && r_fetch_ready;
    assign w_addr_ext     = {1'b0, address};
    assign w_addr_oob     = (w_addr_ext >= c_depth);
    assign w_addr_loaded  = (w_addr_ext < r_load_count);
    assign w_rd_en        = w_fetch_accept && !w_addr_oob && w_addr_loaded;

    instr_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk     (clk),
        .wr_en   (w_load_accept),
        .wr_addr (r_wr_ptr[IDX_W-1:0]),
        .wr_data (load_data),
        .rd_en   (w_rd_en),
        .rd_addr (address[IDX_W-1:0]),
        .rd_data (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_wr_ptr      <= '0;
            r_load_count  <= '0;
            r_load_ready  <= 1'b0;
            r_load_done   <= 1'b0;
            r_fetch_ready <= 1'b0;
            r_out_valid   <= 1'b0;
            r_addr_fault  <= 1'b0;
            r_use_nop     <= 1'b1;
        end else begin
            r_load_done <= 1'b0;
            r_out_valid <= w_fetch_accept;
            if (w_fetch_accept) begin
                r_addr_fault <= w_addr_oob;
                r_use_nop    <= w_addr_oob || !w_addr_loaded;
            end

            if (load_start) begin
                r_state       <= LOAD;
                r_wr_ptr      <= '0;
                r_load_count  <= '0;
                r_load_ready  <= 1'b1;
                r_fetch_ready <= 1'b0;
            end else if (w_load_accept) begin
                r_wr_ptr     <= r_wr_ptr + c_one;
                r_load_count <= (r_load_count == c_depth) ? r_load_count
                                                           : r_load_count + c_one;
                if (w_last_word) begin
                    r_state       <= RUN;
                    r_load_ready  <= 1'b0;
                    r_fetch_ready <= 1'b1;
                    r_load_done   <= 1'b1;
                end else begin
                    r_load_ready  <= ((r_wr_ptr + c_one) < c_depth);
                end
            end
        end
    end

    assign load_ready  = r_load_ready;
    assign load_done   = r_load_done;
    // Clamp only matters when DEPTH equals 2**ADDR_WIDTH.
    assign load_count  = (r_load_count > c_count_max) ? '1 : r_load_count[ADDR_WIDTH-1:0];
    assign fetch_ready = r_fetch_ready;
    assign out_valid   = r_out_valid;
    assign addr_fault  = r_addr_fault;
    assign out         = r_use_nop ? NOP_WORD : w_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loadable.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_mem_loadable
//  Description : Directed self-checking bench for instr_mem_loadable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_loadable;

    logic        clk;
    logic        rst_n;
    logic        load_start;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        load_done;
    logic [15:0] load_count;
    logic        fetch_req;
    logic [15:0] address;
    logic        fetch_ready;
    logic        out_valid;
    logic [15:0] out;
    logic        addr_fault;

    int checks   = 0;
    int failures = 0;

    instr_mem_loadable dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .load_count  (load_count),
        .fetch_req   (fetch_req),
        .address     (address),
        .fetch_ready (fetch_ready),
        .out_valid   (out_valid),
        .out         (out),
        .addr_fault  (addr_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_data = '0;
        load_last = 1'b0; fetch_req = 1'b0; address = '0;
        tick(); tick();
        check("rst_load_ready", 32'(load_ready), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_count", 32'(load_count), 32'd0);
        check("rst_fetch_ready", 32'(fetch_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_addr_fault", 32'(addr_fault), 32'd0);
        check("rst_out", 32'(out), 32'h0000);
        rst_n = 1'b1;
        tick();

        // Fetch in IDLE is ignored
        fetch_req = 1'b1; address = 16'd0;
        tick();
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_fetch_ready", 32'(fetch_ready), 32'd0);
        check("idle_load_ready", 32'(load_ready), 32'd0);
        check("idle_out", 32'(out), 32'h0000);
        fetch_req = 1'b0;

        // Three-word load
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("load_ready_in_load", 32'(load_ready), 32'd1);
        check("fetch_ready_in_load", 32'(fetch_ready), 32'd0);
        load_valid = 1'b1; load_data = 16'h1111; tick();
        check("no_done_mid_load", 32'(load_done), 32'd0);
        load_data = 16'h2222; tick();
        load_data = 16'h3333; load_last = 1'b1; tick();
        load_valid = 1'b0; load_last = 1'b0;
        check("t2_load_done", 32'(load_done), 32'd1);
        check("t2_load_count", 32'(load_count), 32'd3);
        check("t2_fetch_ready", 32'(fetch_ready), 32'd1);
        check("t2_load_ready", 32'(load_ready), 32'd0);

        // Back-to-back fetches
        fetch_req = 1'b1; address = 16'd0; tick();
        check("t2_done_single", 32'(load_done), 32'd0);
        check("t2_f0_valid", 32'(out_valid), 32'd1);
        check("t2_f0_out", 32'(out), 32'h1111);
        address = 16'd1; tick();
        check("t2_f1_valid", 32'(out_valid), 32'd1);
        check("t2_f1_out", 32'(out), 32'h2222);
        address = 16'd2; tick();
        check("t2_f2_out", 32'(out), 32'h3333);
        fetch_req = 1'b0; tick();
        check("t2_idle_valid", 32'(out_valid), 32'd0);
        check("t2_hold_out", 32'(out), 32'h3333);

        // Unloaded and out-of-range addresses
        fetch_req = 1'b1; address = 16'd5; tick();
        check("t3_unloaded_out", 32'(out), 32'h0000);
        check("t3_unloaded_fault", 32'(addr_fault), 32'd0);
        check("t3_unloaded_valid", 32'(out_valid), 32'd1);
        address = 16'd64; tick();
        check("t3_oob_out", 32'(out), 32'h0000);
        check("t3_oob_fault", 32'(addr_fault), 32'd1);
        address = 16'hFFFF; tick();
        check("t3_oob_max_fault", 32'(addr_fault), 32'd1);
        fetch_req = 1'b0;

        // Fetch concurrent with load_start sees pre-load contents
        fetch_req = 1'b1; address = 16'd1; load_start = 1'b1;
        load_valid = 1'b1; load_data = 16'hBEEF;
        tick();
        fetch_req = 1'b0; load_start = 1'b0;
        check("t5_fetch_valid", 32'(out_valid), 32'd1);
        check("t5_fetch_old", 32'(out), 32'h2222);
        check("t5_fault", 32'(addr_fault), 32'd0);
        check("t5_count_cleared", 32'(load_count), 32'd0);
        check("t5_fetch_ready", 32'(fetch_ready), 32'd0);
        load_data = 16'h1111; tick();
        load_data = 16'hAAAA; load_last = 1'b1; tick();
        load_valid = 1'b0; load_last = 1'b0;
        check("t5_load_done", 32'(load_done), 32'd1);
        check("t5_load_count", 32'(load_count), 32'd2);
        fetch_req = 1'b1; address = 16'd1; tick();
        check("t5_new_word", 32'(out), 32'hAAAA);
        address = 16'd0; tick();
        check("t5_word0", 32'(out), 32'h1111);
        address = 16'd2; tick();
        check("t5_stale_hidden", 32'(out), 32'h0000);
        check("t5_stale_fault", 32'(addr_fault), 32'd0);
        fetch_req = 1'b0;

        // Full-depth load without load_last
        load_start = 1'b1; tick();
        load_start = 1'b0; load_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            load_data = 16'h4000 + 16'(i);
            tick();
            if (i == 62) check("t4_no_early_done", 32'(load_done), 32'd0);
        end
        check("t4_load_done", 32'(load_done), 32'd1);
        check("t4_load_count", 32'(load_count), 32'd64);
        check("t4_load_ready", 32'(load_ready), 32'd0);
        check("t4_fetch_ready", 32'(fetch_ready), 32'd1);
        load_data = 16'hDEAD; tick();
        load_valid = 1'b0;
        check("t4_extra_count", 32'(load_count), 32'd64);
        check("t4_extra_done", 32'(load_done), 32'd0);
        fetch_req = 1'b1; address = 16'd63; tick();
        check("t4_last_word", 32'(out), 32'h403F);
        check("t4_last_fault", 32'(addr_fault), 32'd0);
        address = 16'd0; tick();
        check("t4_first_word", 32'(out), 32'h4000);
        fetch_req = 1'b0;

        // Reset in the middle of a load
        load_start = 1'b1; tick();
        load_start = 1'b0; load_valid = 1'b1;
        load_data = 16'h5555; tick();
        load_data = 16'h6666; tick();
        load_data = 16'h7777; load_last = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("t6_load_ready", 32'(load_ready), 32'd0);
        check("t6_load_count", 32'(load_count), 32'd0);
        check("t6_fetch_ready", 32'(fetch_ready), 32'd0);
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_out", 32'(out), 32'h0000);
        check("t6_fault", 32'(addr_fault), 32'd0);
        load_valid = 1'b0; load_last = 1'b0;
        #1 rst_n = 1'b1;
        fetch_req = 1'b1; address = 16'd0;
        tick(); tick();
        check("t6_fetch_ignored", 32'(out_valid), 32'd0);
        check("t6_fetch_out", 32'(out), 32'h0000);
        fetch_req = 1'b0;
        load_start = 1'b1; tick();
        load_start = 1'b0; load_valid = 1'b1; load_last = 1'b1;
        load_data = 16'h5A5A; tick();
        load_valid = 1'b0; load_last = 1'b0;
        check("t6_reload_done", 32'(load_done), 32'd1);
        check("t6_reload_count", 32'(load_count), 32'd1);
        fetch_req = 1'b1; address = 16'd0; tick();
        check("t6_reload_word", 32'(out), 32'h5A5A);
        address = 16'd1; tick();
        check("t6_old_hidden", 32'(out), 32'h0000);
        fetch_req = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
